// File: rtl/sample_rate_smoother.sv
// sample_rate_smoother
// Absorbs the bursty output of the upstream polyphase resampler in a small
// circular FIFO and releases one sample every OUT_DIV clocks. Streaming starts
// once PREFILL samples are buffered. It falls back to prefilling whenever an
// output slot finds the FIFO empty.
module sample_rate_smoother #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PREFILL    = 4,
  parameter int OUT_DIV    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
  input  logic                          data_in_valid,
  input  logic                          clear_flags,
  output logic signed [DATA_WIDTH-1:0]  data_out,
  output logic                          data_out_valid,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          stream_active
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  localparam logic [PTR_W:0]   LVL_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LVL_PREFILL = (PTR_W+1)'(PREFILL);
  localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(OUT_DIV - 1);

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_STREAM  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Sample storage is never reset; only pointers and occupancy define validity.
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] slot_cnt;

  logic tick;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic ovf_evt;
  logic udf_evt;

  // Emptiness and fullness come from the registered level, so a push in the
  // same cycle cannot rescue an empty slot, and a pop can make room for a push
  // into a full FIFO.
  assign fifo_empty = (fill_level == '0);
  assign fifo_full  = (fill_level == LVL_FULL);
  assign pop        = tick && !fifo_empty;
  assign push       = data_in_valid && (!fifo_full || pop);
  assign ovf_evt    = data_in_valid && fifo_full && !pop;
  assign udf_evt    = tick && fifo_empty;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PREFILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start streaming once enough samples are buffered, fall back on an empty slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PREFILL: if (fill_level >= LVL_PREFILL) state_d = ST_STREAM;
      ST_STREAM:  if (udf_evt) state_d = ST_PREFILL;
      default:    state_d = ST_PREFILL;
    endcase
  end

  // FSM outputs: streaming indicator and the output-slot tick
  always_comb begin
    stream_active = (state_q == ST_STREAM);
    tick          = (state_q == ST_STREAM) && (slot_cnt == SLOT_LAST);
  end

  // Slot counter paces the output; it sits at 0 outside STREAM, so it starts from 0 on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (state_q != ST_STREAM) begin
      slot_cnt <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy is tracked separately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        fill_level <= fill_level + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        fill_level <= fill_level - (PTR_W+1)'(1);
      end
    end
  end

  // Stage p0 -> output register: popped head goes out one clock after the tick; data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= pop;
      if (pop) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Sticky flags: a new event in the same cycle as clear_flags keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_rate_smoother.sv
// Testbench for sample_rate_smoother (DEPTH=8, PREFILL=4, OUT_DIV=3).
// Expected samples are queued as they are driven and consumed by a monitor
// whenever data_out_valid is seen. Timing and flag behaviour are checked inline
// by each scenario task.
module tb_sample_rate_smoother;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 8;
  localparam int PREFILL    = 4;
  localparam int OUT_DIV    = 3;
  localparam int FW         = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic                         clear_flags;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         data_out_valid;
  logic [FW-1:0]                fill_level;
  logic                         overflow;
  logic                         underflow;
  logic                         stream_active;

  int n_checks  = 0;
  int n_fail    = 0;
  int out_count = 0;

  logic signed [DATA_WIDTH-1:0] sbq [$];
  logic signed [DATA_WIDTH-1:0] sb_exp;

  sample_rate_smoother #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PREFILL    (PREFILL),
    .OUT_DIV    (OUT_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .clear_flags    (clear_flags),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .underflow      (underflow),
    .stream_active  (stream_active)
  );

  always #5 clk = ~clk;

  // Scoreboard: every output sample must be the oldest outstanding expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_out_valid === 1'b1) begin
      out_count++;
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: data_out=%0d appeared, required no output", data_out);
      end else begin
        sb_exp = sbq.pop_front();
        if (data_out !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_data: data_out=%0d, required %0d", data_out, sb_exp);
        end
      end
    end
  end

  // Drive one clock of input, then settle just after the edge
  task automatic step(input logic v, input logic signed [DATA_WIDTH-1:0] d, input logic clr);
    data_in_valid = v;
    data_in       = d;
    clear_flags   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    data_in_valid = 1'b0;
    data_in       = '0;
    clear_flags   = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sbq.size() != 0; k++) step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; data_in_valid = 1'b0; data_in = '0; clear_flags = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (data_out !== 16'sd0) begin n_fail++; $display("FAIL reset_data_out: got %0d, required 0", data_out); end
    n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", data_out_valid); end
    n_checks++; if (fill_level !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d, required 0", fill_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b, required 0", underflow); end
    n_checks++; if (stream_active !== 1'b0) begin n_fail++; $display("FAIL reset_stream: got %b, required 0", stream_active); end
  endtask

  // Push 1,2,3,4; streaming begins the edge after the 4th push, outputs every OUT_DIV clocks
  task automatic test_prefill_pacing;
    int k_stream;
    int t [$];
    k_stream = -1;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      sbq.push_back(16'(i));
      step(1'b1, 16'(i), 1'b0);
    end
    n_checks++; if (int'(fill_level) !== 4) begin n_fail++; $display("FAIL pace_fill4: got %0d, required 4", fill_level); end
    n_checks++; if (stream_active !== 1'b0) begin n_fail++; $display("FAIL pace_not_yet: stream_active=%b, required 0", stream_active); end
    for (int k = 5; k <= 22; k++) begin
      step(1'b0, '0, 1'b0);
      if (stream_active === 1'b1 && k_stream < 0) k_stream = k;
      if (data_out_valid === 1'b1) t.push_back(k);
    end
    n_checks++; if (k_stream !== 5) begin n_fail++; $display("FAIL pace_stream_rise: edge %0d, required 5", k_stream); end
    n_checks++; if (t.size() !== 4) begin n_fail++; $display("FAIL pace_count: %0d outputs, required 4", t.size()); end
    if (t.size() > 0) begin
      n_checks++;
      if (t[0] - k_stream !== OUT_DIV) begin
        n_fail++; $display("FAIL pace_first_latency: %0d edges after stream_active, required %0d", t[0] - k_stream, OUT_DIV);
      end
    end
    for (int i = 1; i < t.size(); i++) begin
      n_checks++;
      if (t[i] - t[i-1] !== OUT_DIV) begin
        n_fail++; $display("FAIL pace_gap: gap %0d, required %0d", t[i] - t[i-1], OUT_DIV);
      end
    end
    n_checks++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL pace_drained: %0d samples left, required 0", sbq.size()); end
  endtask

  // Pairs of samples every 6 clocks match the 1-per-3 output rate exactly
  task automatic test_bursty;
    int t [$];
    int maxfill;
    int k;
    logic flag_seen;
    logic signed [DATA_WIDTH-1:0] v;
    maxfill = 0; flag_seen = 1'b0; k = 0;
    do_reset();
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 6; c++) begin
        k++;
        if (c < 2) begin
          if (p == 0) v = (c == 0) ? 16'sh8000 : 16'sh7FFF;
          else        v = 16'($urandom);
          sbq.push_back(v);
          step(1'b1, v, 1'b0);
        end else begin
          step(1'b0, '0, 1'b0);
        end
        if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
        if (overflow !== 1'b0 || underflow !== 1'b0) flag_seen = 1'b1;
        if (data_out_valid === 1'b1) t.push_back(k);
      end
    end
    n_checks++; if (flag_seen !== 1'b0) begin n_fail++; $display("FAIL burst_flags: a flag was set, required none"); end
    n_checks++; if (maxfill > PREFILL + 2) begin n_fail++; $display("FAIL burst_fill_bound: max %0d, required <= %0d", maxfill, PREFILL + 2); end
    n_checks++; if (t.size() !== 17) begin n_fail++; $display("FAIL burst_count: %0d outputs, required 17", t.size()); end
    for (int i = 1; i < t.size(); i++) begin
      n_checks++;
      if (t[i] - t[i-1] !== OUT_DIV) begin
        n_fail++; $display("FAIL burst_gap: gap %0d at edge %0d, required %0d", t[i] - t[i-1], t[i], OUT_DIV);
      end
    end
    drain(40);
    n_checks++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL burst_drained: %0d samples left, required 0", sbq.size()); end
  endtask

  // 11 back-to-back pushes: sample 10 meets a full FIFO with no pop and is dropped;
  // sample 11 arrives with a pop and is kept
  task automatic test_overflow;
    int maxfill;
    logic signed [DATA_WIDTH-1:0] v;
    maxfill = 0;
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      v = 16'(100 + i);
      if (i != 10) sbq.push_back(v);
      step(1'b1, v, 1'b0);
      if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    n_checks++; if (maxfill !== DEPTH) begin n_fail++; $display("FAIL ovf_max_fill: got %0d, required %0d", maxfill, DEPTH); end
    n_checks++; if (int'(fill_level) !== DEPTH) begin n_fail++; $display("FAIL ovf_fill: got %0d, required %0d", fill_level, DEPTH); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_no_underflow: got %b, required 0", underflow); end
  endtask

  // Continues from the full FIFO left by test_overflow (no pop in the next two clocks)
  task automatic test_clear_flags;
    step(1'b1, 16'sh0EEE, 1'b1);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins: overflow=%b, required 1", overflow); end
    n_checks++; if (int'(fill_level) !== DEPTH) begin n_fail++; $display("FAIL clr_fill: got %0d, required %0d", fill_level, DEPTH); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_alone: overflow=%b, required 0", overflow); end
    clear_flags = 1'b0;
    drain(40);
    n_checks++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL clr_drained: %0d samples left, required 0", sbq.size()); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_stays_clear: overflow=%b, required 0", overflow); end
  endtask

  // 4 samples, then starvation; a push coincident with the empty tick is retained
  task automatic test_underflow;
    int base;
    do_reset();
    base = out_count;
    for (int k = 1; k <= 4; k++) begin
      sbq.push_back(16'(200 + k));
      step(1'b1, 16'(200 + k), 1'b0);
    end
    for (int k = 5; k <= 19; k++) step(1'b0, '0, 1'b0);
    n_checks++; if (out_count - base !== 4) begin n_fail++; $display("FAIL udf_four_out: %0d outputs, required 4", out_count - base); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_not_yet: got %b, required 0", underflow); end
    n_checks++; if (stream_active !== 1'b1) begin n_fail++; $display("FAIL udf_still_stream: got %b, required 1", stream_active); end
    sbq.push_back(-16'sd300);
    step(1'b1, -16'sd300, 1'b0);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b, required 1", underflow); end
    n_checks++; if (stream_active !== 1'b0) begin n_fail++; $display("FAIL udf_back_prefill: got %b, required 0", stream_active); end
    n_checks++; if (int'(fill_level) !== 1) begin n_fail++; $display("FAIL udf_push_kept: fill %0d, required 1", fill_level); end
    for (int k = 21; k <= 22; k++) begin
      sbq.push_back(16'(200 + k));
      step(1'b1, 16'(200 + k), 1'b0);
    end
    n_checks++; if (stream_active !== 1'b0) begin n_fail++; $display("FAIL udf_wait_prefill: got %b, required 0", stream_active); end
    n_checks++; if (int'(fill_level) !== 3) begin n_fail++; $display("FAIL udf_fill3: got %0d, required 3", fill_level); end
    sbq.push_back(16'sd223);
    step(1'b1, 16'sd223, 1'b0);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %b, required 1", underflow); end
    drain(40);
    n_checks++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL udf_resume: %0d samples left, required 0", sbq.size()); end
    n_checks++; if (out_count - base !== 8) begin n_fail++; $display("FAIL udf_total_out: %0d outputs, required 8", out_count - base); end
  endtask

  // Reset while holding 5 samples and presenting an output; then restart cleanly
  task automatic test_midstream_reset;
    logic got;
    got = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      sbq.push_back(16'(300 + i));
      step(1'b1, 16'(300 + i), 1'b0);
    end
    for (int k = 9; k <= 14; k++) step(1'b0, '0, 1'b0);
    n_checks++; if (int'(fill_level) !== 5) begin n_fail++; $display("FAIL mrst_pre_fill: got %0d, required 5", fill_level); end
    n_checks++; if (data_out_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_valid: got %b, required 1", data_out_valid); end
    rst_n = 1'b0;
    sbq.delete();
    #1;
    n_checks++; if (data_out !== 16'sd0) begin n_fail++; $display("FAIL mrst_data_out: got %0d, required 0", data_out); end
    n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b, required 0", data_out_valid); end
    n_checks++; if (fill_level !== '0) begin n_fail++; $display("FAIL mrst_fill: got %0d, required 0", fill_level); end
    n_checks++; if (stream_active !== 1'b0) begin n_fail++; $display("FAIL mrst_stream: got %b, required 0", stream_active); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sbq.push_back(16'(-1000 * i));
      step(1'b1, 16'(-1000 * i), 1'b0);
    end
    for (int k = 0; k < 20 && !got; k++) begin
      step(1'b0, '0, 1'b0);
      if (data_out_valid === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (data_out !== -16'sd1000) begin n_fail++; $display("FAIL mrst_first_out: got %0d, required -1000", data_out); end
      end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL mrst_timeout: no output within 20 clocks, required one"); end
    drain(40);
    n_checks++; if (sbq.size() !== 0) begin n_fail++; $display("FAIL mrst_drained: %0d samples left, required 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_prefill_pacing();
    test_bursty();
    test_overflow();
    test_clear_flags();
    test_underflow();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
